// File: rtl/alu16_sequencer.sv
// alu16_sequencer: runs the SM83 16-bit arithmetic ops (ADD HL,rr / INC rr /
// DEC rr / ADD SP,e8) as a low-byte pass followed by a high-byte pass through
// the shared 8-bit ALU, then hands the 16-bit result and ZNHC flags back.
// Optional build macro: ALU16_BACK_TO_BACK_EN lets a new START be taken in the
// DONE state so ops can issue every 3 cycles instead of every 4.
module alu16_sequencer (
  input  logic        CLK,
  input  logic        RST,
  input  logic        START,
  input  logic [1:0]  OP,
  input  logic [15:0] OPA,
  input  logic [15:0] OPB,
  input  logic [3:0]  FLAGS_CUR,
  output logic        BUSY,
  output logic        DONE,
  output logic [15:0] RESULT,
  output logic [3:0]  FLAGS_NEW,
  output logic [4:0]  ALU_FUN,
  output logic [7:0]  ALU_A,
  output logic [7:0]  ALU_B,
  output logic [3:0]  ALU_FLAGS_IN,
  input  logic [7:0]  ALU_OUT,
  input  logic [3:0]  ALU_FLAGS_OUT
);

  localparam logic [4:0] FUN_ADD = 5'b00000;
  localparam logic [4:0] FUN_ADC = 5'b00001;
  localparam logic [4:0] FUN_SUB = 5'b00010;
  localparam logic [4:0] FUN_SBC = 5'b00011;

  localparam logic [1:0] OP_ADD16 = 2'd0;
  localparam logic [1:0] OP_INC16 = 2'd1;
  localparam logic [1:0] OP_DEC16 = 2'd2;
  localparam logic [1:0] OP_ADDSP = 2'd3;

  typedef enum logic [1:0] {S_IDLE, S_LO, S_HI, S_DONE} state_t;

  state_t      state;
  state_t      state_next;
  logic        accept;
  logic [1:0]  op_q;
  logic [15:0] opa_q;
  logic [15:0] opb_q;
  logic [3:0]  flags_cur_q;
  logic [7:0]  lo_byte_q;
  logic [1:0]  lo_hc_q;
  logic [3:0]  flags_final;
  logic        unused_alu_zn;

  // Only H and C from the ALU are ever consumed; Z/N are recomputed per op.
  assign unused_alu_zn = ^ALU_FLAGS_OUT[3:2];

  // A START is taken in IDLE, and also in DONE when back-to-back issue is built in.
  always_comb begin
    accept = 1'b0;
`ifdef ALU16_BACK_TO_BACK_EN
    accept = START && ((state == S_IDLE) || (state == S_DONE));
`else
    accept = START && (state == S_IDLE);
`endif
  end

  // State register with synchronous reset.
  always_ff @(posedge CLK) begin
    if (RST) state <= S_IDLE;
    else     state <= state_next;
  end

  // Next-state sequencing: IDLE -> LO -> HI -> DONE -> IDLE (or LO on accept).
  always_comb begin
    state_next = state;
    case (state)
      S_IDLE:  if (accept) state_next = S_LO;
      S_LO:    state_next = S_HI;
      S_HI:    state_next = S_DONE;
      S_DONE:  state_next = accept ? S_LO : S_IDLE;
      default: state_next = S_IDLE;
    endcase
  end

  // Drive the 8-bit ALU: low byte in LO, high byte with carry/borrow in HI, zeros otherwise.
  always_comb begin
    ALU_FUN      = FUN_ADD;
    ALU_A        = 8'h00;
    ALU_B        = 8'h00;
    ALU_FLAGS_IN = 4'b0000;
    case (state)
      S_LO: begin
        ALU_A = opa_q[7:0];
        case (op_q)
          OP_INC16: begin ALU_FUN = FUN_ADD; ALU_B = 8'h01;       end
          OP_DEC16: begin ALU_FUN = FUN_SUB; ALU_B = 8'h01;       end
          default:  begin ALU_FUN = FUN_ADD; ALU_B = opb_q[7:0];  end
        endcase
      end
      S_HI: begin
        ALU_A        = opa_q[15:8];
        ALU_FLAGS_IN = {3'b000, lo_hc_q[0]};
        case (op_q)
          OP_ADD16: begin ALU_FUN = FUN_ADC; ALU_B = opb_q[15:8];     end
          OP_INC16: begin ALU_FUN = FUN_ADC; ALU_B = 8'h00;           end
          OP_DEC16: begin ALU_FUN = FUN_SBC; ALU_B = 8'h00;           end
          default:  begin ALU_FUN = FUN_ADC; ALU_B = {8{opb_q[7]}};   end
        endcase
      end
      default: ;
    endcase
  end

  // Final ZNHC selection, evaluated while the high-byte pass is on the ALU.
  always_comb begin
    flags_final = flags_cur_q;
    case (op_q)
      OP_ADD16: flags_final = {flags_cur_q[3], 1'b0, ALU_FLAGS_OUT[1], ALU_FLAGS_OUT[0]};
      OP_ADDSP: flags_final = {1'b0, 1'b0, lo_hc_q[1], lo_hc_q[0]};
      default:  flags_final = flags_cur_q;
    endcase
  end

  // Operand capture on accept, low-byte capture after LO, result/flags commit after HI.
  always_ff @(posedge CLK) begin
    if (RST) begin
      op_q        <= 2'd0;
      opa_q       <= 16'h0000;
      opb_q       <= 16'h0000;
      flags_cur_q <= 4'b0000;
      lo_byte_q   <= 8'h00;
      lo_hc_q     <= 2'b00;
      RESULT      <= 16'h0000;
      FLAGS_NEW   <= 4'b0000;
    end else begin
      if (accept) begin
        op_q        <= OP;
        opa_q       <= OPA;
        opb_q       <= OPB;
        flags_cur_q <= FLAGS_CUR;
      end
      if (state == S_LO) begin
        lo_byte_q <= ALU_OUT;
        lo_hc_q   <= ALU_FLAGS_OUT[1:0];
      end
      if (state == S_HI) begin
        RESULT    <= {ALU_OUT, lo_byte_q};
        FLAGS_NEW <= flags_final;
      end
    end
  end

  assign BUSY = (state == S_LO) || (state == S_HI);
  assign DONE = (state == S_DONE);

endmodule

// File: tb/tb_alu16_sequencer.sv
// Testbench for alu16_sequencer: models the 8-bit ALU, keeps a 16-bit
// arithmetic reference model and checks every DUT output on every cycle,
// plus directed literal checks. Honours ALU16_BACK_TO_BACK_EN.
module tb_alu16_sequencer;

  localparam logic [4:0] FUN_ADD = 5'b00000;
  localparam logic [4:0] FUN_ADC = 5'b00001;
  localparam logic [4:0] FUN_SUB = 5'b00010;
  localparam logic [4:0] FUN_SBC = 5'b00011;

`ifdef ALU16_BACK_TO_BACK_EN
  localparam bit B2B = 1'b1;
`else
  localparam bit B2B = 1'b0;
`endif

  logic        CLK = 1'b0;
  logic        RST, START;
  logic [1:0]  OP;
  logic [15:0] OPA, OPB;
  logic [3:0]  FLAGS_CUR;
  logic        BUSY, DONE;
  logic [15:0] RESULT;
  logic [3:0]  FLAGS_NEW;
  logic [4:0]  ALU_FUN;
  logic [7:0]  ALU_A, ALU_B;
  logic [3:0]  ALU_FLAGS_IN;
  logic [7:0]  ALU_OUT;
  logic [3:0]  ALU_FLAGS_OUT;

  int check_cnt = 0;
  int fail_cnt  = 0;
  bit chk_en    = 1'b0;

  alu16_sequencer dut (
    .CLK(CLK), .RST(RST), .START(START), .OP(OP), .OPA(OPA), .OPB(OPB),
    .FLAGS_CUR(FLAGS_CUR), .BUSY(BUSY), .DONE(DONE), .RESULT(RESULT),
    .FLAGS_NEW(FLAGS_NEW), .ALU_FUN(ALU_FUN), .ALU_A(ALU_A), .ALU_B(ALU_B),
    .ALU_FLAGS_IN(ALU_FLAGS_IN), .ALU_OUT(ALU_OUT), .ALU_FLAGS_OUT(ALU_FLAGS_OUT)
  );

  always #5 CLK = ~CLK;

  // SM83-style 8-bit ALU: returns {flags[3:0], out[7:0]}
  function automatic logic [11:0] alu_eval(input logic [4:0] fun, input logic [7:0] a,
                                           input logic [7:0] b, input logic [3:0] fin);
    int ai, bi, cin, r;
    logic h, c, n;
    ai  = int'(a);
    bi  = int'(b);
    cin = (fun == FUN_ADC || fun == FUN_SBC) ? int'(fin[0]) : 0;
    if (fun == FUN_ADD || fun == FUN_ADC) begin
      r = ai + bi + cin;
      n = 1'b0;
      h = ((ai & 15) + (bi & 15) + cin) > 15;
      c = r > 255;
    end else if (fun == FUN_SUB || fun == FUN_SBC) begin
      r = ai - bi - cin;
      n = 1'b1;
      h = (ai & 15) < ((bi & 15) + cin);
      c = ai < (bi + cin);
    end else begin
      r = 0; n = 1'b0; h = 1'b0; c = 1'b0;
    end
    alu_eval = {((r & 255) == 0), n, h, c, 8'(r & 255)};
  endfunction

  // The ALU is combinational, driven straight from the DUT.
  always_comb begin
    logic [11:0] res;
    res           = alu_eval(ALU_FUN, ALU_A, ALU_B, ALU_FLAGS_IN);
    ALU_OUT       = res[7:0];
    ALU_FLAGS_OUT = res[11:8];
  end

  // Reference 16-bit result from plain arithmetic
  function automatic logic [15:0] ref_result(input int op, input int a, input int b);
    int e;
    e = b & 255;
    if (e >= 128) e = e - 256;
    case (op)
      0:       ref_result = 16'((a + (b & 'hFFFF)) & 'hFFFF);
      1:       ref_result = 16'((a + 1) & 'hFFFF);
      2:       ref_result = 16'((a - 1) & 'hFFFF);
      default: ref_result = 16'((a + e) & 'hFFFF);
    endcase
  endfunction

  // Reference final flags {Z,N,H,C}
  function automatic logic [3:0] ref_flags(input int op, input int a, input int b, input logic [3:0] f);
    case (op)
      0: ref_flags = {f[3], 1'b0, ((a & 'hFFF) + (b & 'hFFF)) > 'hFFF, (a + b) > 'hFFFF};
      1, 2: ref_flags = f;
      default: ref_flags = {2'b00, ((a & 'hF) + (b & 'hF)) > 'hF, ((a & 'hFF) + (b & 'hFF)) > 'hFF};
    endcase
  endfunction

  task automatic checkOutput(input string name, input logic [15:0] act, input logic [15:0] exp);
    check_cnt++;
    if (act !== exp) begin
      fail_cnt++;
      $display("[TB] FAIL %s: got %0h, expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference model: cycles since accept (0 none, 1 low pass, 2 high pass, 3 done)
  int          m_phase = 0;
  int          m_op, m_a, m_b;
  logic [3:0]  m_f;
  logic [15:0] m_result = 16'h0;
  logic [3:0]  m_flags  = 4'h0;

  always @(posedge CLK) begin
    bit acc;
    if (RST) begin
      m_phase = 0; m_result = 16'h0; m_flags = 4'h0;
    end else begin
      acc = START && (m_phase == 0 || (B2B && m_phase == 3));
      if (m_phase == 2) begin
        m_result = ref_result(m_op, m_a, m_b);
        m_flags  = ref_flags(m_op, m_a, m_b, m_f);
      end
      if (acc) begin
        m_op = int'(OP); m_a = int'(OPA); m_b = int'(OPB); m_f = FLAGS_CUR;
        m_phase = 1;
      end else if (m_phase == 3) m_phase = 0;
      else if (m_phase != 0)     m_phase = m_phase + 1;
    end
  end

  logic [4:0] e_fun;
  logic [7:0] e_a, e_b;
  logic [3:0] e_fin;

  // Compare every DUT output against the model on each falling edge
  always @(negedge CLK) begin
    if (chk_en) begin
      e_fun = FUN_ADD; e_a = 8'h0; e_b = 8'h0; e_fin = 4'h0;
      if (m_phase == 1) begin
        e_fun = (m_op == 2) ? FUN_SUB : FUN_ADD;
        e_a   = 8'(m_a & 255);
        e_b   = (m_op == 1 || m_op == 2) ? 8'h01 : 8'(m_b & 255);
      end else if (m_phase == 2) begin
        e_fun = (m_op == 2) ? FUN_SBC : FUN_ADC;
        e_a   = 8'((m_a >> 8) & 255);
        e_b   = (m_op == 0) ? 8'((m_b >> 8) & 255) :
                (m_op == 3) ? (((m_b & 128) != 0) ? 8'hFF : 8'h00) : 8'h00;
        if (m_op == 1)      e_fin = {3'b000, (m_a & 255) == 255};
        else if (m_op == 2) e_fin = {3'b000, (m_a & 255) == 0};
        else                e_fin = {3'b000, ((m_a & 255) + (m_b & 255)) > 255};
      end
      checkOutput("busy",      16'(BUSY), 16'(m_phase == 1 || m_phase == 2));
      checkOutput("done",      16'(DONE), 16'(m_phase == 3));
      checkOutput("result",    RESULT, m_result);
      checkOutput("flags_new", 16'(FLAGS_NEW), 16'(m_flags));
      checkOutput("alu_fun",   16'(ALU_FUN), 16'(e_fun));
      checkOutput("alu_a",     16'(ALU_A), 16'(e_a));
      checkOutput("alu_b",     16'(ALU_B), 16'(e_b));
      checkOutput("alu_fin",   16'(ALU_FLAGS_IN), 16'(e_fin));
    end
  end

  // Issue one op at a falling edge; returns in cycle 1 with inputs scrambled
  task automatic applyStimulus(input logic [1:0] op, input logic [15:0] a, input logic [15:0] b,
                               input logic [3:0] f);
    @(negedge CLK);
    START = 1'b1; OP = op; OPA = a; OPB = b; FLAGS_CUR = f;
    @(negedge CLK);
    START = 1'b0; OP = 2'($urandom); OPA = 16'($urandom); OPB = 16'($urandom);
    FLAGS_CUR = 4'($urandom);
  endtask

  // Wait (bounded) for DONE; reports the cycle index counted from the START cycle
  task automatic waitDone(input string name);
    int cyc;
    cyc = -1;
    for (int i = 1; i <= 6; i++) begin
      @(negedge CLK);
      if (DONE === 1'b1) begin cyc = i + 1; break; end
    end
    checkOutput(name, 16'(cyc), 16'd3);
  endtask

  initial begin
    int cyc;
    RST = 1'b1; START = 1'b0; OP = 2'd0; OPA = 16'h0; OPB = 16'h0; FLAGS_CUR = 4'h0;
    repeat (2) @(negedge CLK);
    chk_en = 1'b1;
    checkOutput("rst_result", RESULT, 16'h0000);
    checkOutput("rst_flags",  16'(FLAGS_NEW), 16'h0);
    checkOutput("rst_busy",   16'(BUSY), 16'h0);
    checkOutput("rst_alu_a",  16'(ALU_A), 16'h0);
    RST = 1'b0;

    $display("[TB] directed ADD16");
    applyStimulus(2'd0, 16'h8A23, 16'h0605, 4'b1000);
    checkOutput("add_lo_fun", 16'(ALU_FUN), 16'(FUN_ADD));
    checkOutput("add_lo_a",   16'(ALU_A), 16'h23);
    checkOutput("add_lo_b",   16'(ALU_B), 16'h05);
    @(negedge CLK);
    checkOutput("add_hi_fun", 16'(ALU_FUN), 16'(FUN_ADC));
    checkOutput("add_hi_a",   16'(ALU_A), 16'h8A);
    checkOutput("add_hi_b",   16'(ALU_B), 16'h06);
    checkOutput("add_hi_fin", 16'(ALU_FLAGS_IN), 16'h0);
    @(negedge CLK);
    checkOutput("add_done_c3", 16'(DONE), 16'h1);
    checkOutput("add_result",  RESULT, 16'h9028);
    checkOutput("add_flags",   16'(FLAGS_NEW), 16'b1010);

    $display("[TB] directed INC16/DEC16 wrap");
    applyStimulus(2'd1, 16'hFFFF, 16'h1234, 4'b0101);
    waitDone("inc_latency");
    checkOutput("inc_result", RESULT, 16'h0000);
    checkOutput("inc_flags",  16'(FLAGS_NEW), 16'b0101);
    applyStimulus(2'd2, 16'h0000, 16'h0000, 4'b1010);
    waitDone("dec_latency");
    checkOutput("dec_result", RESULT, 16'hFFFF);
    checkOutput("dec_flags",  16'(FLAGS_NEW), 16'b1010);

    $display("[TB] directed ADDSP");
    applyStimulus(2'd3, 16'h0005, 16'h00FE, 4'b1111);
    waitDone("sp_neg_latency");
    checkOutput("sp_neg_result", RESULT, 16'h0003);
    checkOutput("sp_neg_flags",  16'(FLAGS_NEW), 16'b0011);
    applyStimulus(2'd3, 16'h00FF, 16'h0001, 4'b1000);
    waitDone("sp_pos_latency");
    checkOutput("sp_pos_result", RESULT, 16'h0100);
    checkOutput("sp_pos_flags",  16'(FLAGS_NEW), 16'b0011);

    $display("[TB] START while busy is ignored");
    applyStimulus(2'd1, 16'h1234, 16'h0, 4'b0000);
    START = 1'b1; OP = 2'd2; OPA = 16'h7777;
    @(negedge CLK);
    @(negedge CLK);
    START = 1'b0;
    checkOutput("busy_ign_done",   16'(DONE), 16'h1);
    checkOutput("busy_ign_result", RESULT, 16'h1235);
    @(negedge CLK);
    checkOutput("busy_ign_idle", 16'(BUSY), 16'h0);

    $display("[TB] reset during high pass");
    applyStimulus(2'd0, 16'h1111, 16'h2222, 4'b0000);
    @(negedge CLK);
    RST = 1'b1; START = 1'b1;
    @(negedge CLK);
    RST = 1'b0; START = 1'b0;
    checkOutput("rst_hi_busy",   16'(BUSY), 16'h0);
    checkOutput("rst_hi_done",   16'(DONE), 16'h0);
    checkOutput("rst_hi_result", RESULT, 16'h0000);
    cyc = 0;
    for (int i = 0; i < 4; i++) begin
      @(negedge CLK);
      if (DONE === 1'b1) cyc++;
    end
    checkOutput("rst_hi_no_done", 16'(cyc), 16'h0);

    $display("[TB] START held in DONE");
    applyStimulus(2'd1, 16'h0010, 16'h0, 4'b0000);
    @(negedge CLK);
    @(negedge CLK);
    checkOutput("b2b_first_result", RESULT, 16'h0011);
    START = 1'b1; OP = 2'd2; OPA = 16'h0100;
    @(negedge CLK);
    START = 1'b0;
    cyc = 0;
    for (int i = 1; i <= 5; i++) begin
      @(negedge CLK);
      if (DONE === 1'b1) begin cyc = 4 + i; break; end
    end
    checkOutput("b2b_second_done", 16'(cyc), B2B ? 16'd6 : 16'd0);
    checkOutput("b2b_result", RESULT, B2B ? 16'h00FF : 16'h0011);

    $display("[TB] randomized traffic");
    for (int i = 0; i < 600; i++) begin
      @(negedge CLK);
      RST       = ($urandom_range(0, 59) == 0);
      START     = ($urandom_range(0, 2) == 0);
      OP        = 2'($urandom);
      OPA       = ($urandom_range(0, 7) == 0) ? 16'hFFFF : 16'($urandom);
      OPB       = ($urandom_range(0, 7) == 0) ? 16'h0000 : 16'($urandom);
      FLAGS_CUR = 4'($urandom);
    end
    @(negedge CLK);
    RST = 1'b0; START = 1'b0;
    repeat (5) @(negedge CLK);

    $display("End of test - %0d assertions evaluated, %0d failures", check_cnt, fail_cnt);
    $finish;
  end

  initial begin
    #500000;
    $display("[TB] FAIL watchdog: got timeout, expected completion");
    $fatal(1, "[TB] watchdog expired");
  end

endmodule

// File: doc/alu16_sequencer.md
Name: alu16_sequencer

Overview:
- Multi-cycle sequencer that executes the SM83 16-bit arithmetic ops (ADD HL,rr / INC rr / DEC rr / ADD SP,e8) as two 8-bit passes through the existing 8-bit ALU.
- Sits between the control unit and the ALU:
  - drives ALU_FUN/A/B/FLAGS_IN;
  - consumes ALU_OUT/FLAGS_OUT;
  - returns a 16-bit result and the final ZNHC flags to the register file.

Parameters:
FUN_ADD, 5'b00000, ALU opcode for ADD
FUN_ADC, 5'b00001, ALU opcode for ADC
FUN_SUB, 5'b00010, ALU opcode for SUB
FUN_SBC, 5'b00011, ALU opcode for SBC

Ports:
CLK  in  1  system clock, all state on rising edge
RST  in  1  synchronous, active-high reset
START  in  1  request pulse; sampled only in IDLE
OP  in  2  0=ADD16, 1=INC16, 2=DEC16, 3=ADDSP
OPA  in  16  first operand (HL, rr or SP)
OPB  in  16  second operand (rr for ADD16; [7:0]=signed e8 for ADDSP; unused otherwise)
FLAGS_CUR  in  4  current F register {Z,N,H,C}
BUSY  out  1  high in LO and HI states
DONE  out  1  one-cycle pulse, RESULT/FLAGS_NEW valid
RESULT  out  16  registered result, held until next accepted START
FLAGS_NEW  out  4  registered final flags {Z,N,H,C}
ALU_FUN  out  5  to ALU
ALU_A  out  8  to ALU
ALU_B  out  8  to ALU
ALU_FLAGS_IN  out  4  to ALU
ALU_OUT  in  8  from ALU (combinational)
ALU_FLAGS_OUT  in  4  from ALU (combinational)

Behaviour:
Reset and capture:
- RST (sync, highest priority): state=IDLE; BUSY=0, DONE=0, RESULT=16'h0000, FLAGS_NEW=4'b0000; internal latches cleared.
- RST mid-operation aborts; no DONE is issued.
- START in IDLE latches OP, OPA, OPB and FLAGS_CUR, then moves to LO.
- START in any other state is ignored; latched inputs are not disturbed.

State machine:
- IDLE -> LO on START.
- LO -> HI unconditionally.
- HI -> DONE unconditionally.
- DONE -> IDLE.
- Latency: START in cycle 0, DONE=1 in cycle 3.

ALU drive per state:
- IDLE and DONE: ALU_FUN=FUN_ADD, ALU_A=0, ALU_B=0, ALU_FLAGS_IN=0.
- LO, low byte:
  - ADD16: ADD OPA[7:0], OPB[7:0]
  - INC16: ADD OPA[7:0], 8'h01
  - DEC16: SUB OPA[7:0], 8'h01
  - ADDSP: ADD OPA[7:0], OPB[7:0]
  - ALU_FLAGS_IN=0.
  - End of LO: register ALU_OUT as the result low byte, and ALU_FLAGS_OUT as lo_flags.
- HI, high byte:
  - ADD16: ADC OPA[15:8], OPB[15:8]
  - INC16: ADC OPA[15:8], 8'h00
  - DEC16: SBC OPA[15:8], 8'h00
  - ADDSP: ADC OPA[15:8], {8{OPB[7]}} (sign extension)
  - ALU_FLAGS_IN={3'b000, lo_flags.C}; for SUB/SBC the C bit is borrow.
  - End of HI: register the result high byte and compute FLAGS_NEW.

FLAGS_NEW rules (Z/N/H/C):
- ADD16: Z = latched FLAGS_CUR.Z; N = 0; H = HI-pass H; C = HI-pass C.
- INC16 / DEC16: FLAGS_NEW = latched FLAGS_CUR (no flag change).
- ADDSP: Z = 0; N = 0; H = lo_flags.H; C = lo_flags.C.

Outputs and edge cases:
- RESULT and FLAGS_NEW update together at the HI->DONE edge and hold through IDLE.
- No partial result is ever visible.
- Wrap-around is modulo 2^16: INC16 of 0xFFFF gives 0x0000; DEC16 of 0x0000 gives 0xFFFF.
- OPA/OPB/FLAGS_CUR changing after START has no effect.
- START and RST asserted together: RST wins.

Optional Feature:
- Macro: ALU16_BACK_TO_BACK_EN.
- When defined: START is also accepted in the DONE state. DONE still pulses for the completing op, inputs are latched, and the next state is LO, so back-to-back issue is one op every 3 cycles.
- When undefined: START in DONE is ignored; the minimum issue interval is 4 cycles.

Test Plan:
- ADD16: OPA=0x8A23, OPB=0x0605, FLAGS_CUR=4'b1000 -> DONE in cycle 3; RESULT=0x9028; FLAGS_NEW=4'b1010.
- INC16: OPA=0xFFFF, FLAGS_CUR=4'b0101 -> RESULT=0x0000, FLAGS_NEW=4'b0101. DEC16: OPA=0x0000 -> RESULT=0xFFFF, flags unchanged.
- ADDSP negative e8: OPA=0x0005, OPB[7:0]=0xFE -> RESULT=0x0003, FLAGS_NEW=4'b0011. Positive e8: OPA=0x00FF, e8=0x01 -> RESULT=0x0100, FLAGS_NEW=4'b0011.
- ALU drive: during LO/HI of ADD16 0x8A23+0x0605, ALU_FUN/A/B equal ADD/0x23/0x05 then ADC/0x8A/0x06 with ALU_FLAGS_IN=0000. In IDLE, all ALU outputs are 0.
- START asserted while BUSY with a different OP -> ignored; the original result completes. RST in HI -> next cycle IDLE, BUSY=0, DONE never pulses, RESULT=0x0000.
- ALU16_BACK_TO_BACK_EN: START held in DONE -> second DONE exactly 3 cycles after the first. Without the macro, the same stimulus gives no second op.
